tt_pin_sequencer: RTL and testbench



---
 rtl/tt_pin_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_tt_pin_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_pin_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tt_pin_sequencer                                              |
// | Replays buffered pin vectors into a user tile and checks uo_out.       |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tt_pin_sequencer #(
  parameter int DEPTH      = 16,
  parameter int SETTLE     = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [31:0]              ld_data,
  input  logic                     clear,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_count,
  output logic [$clog2(DEPTH)-1:0] first_fail_idx,
  output logic [$clog2(DEPTH):0]   vec_count,
  output logic [7:0]               dut_ui_in,
  output logic [7:0]               dut_uio_in,
  output logic                     dut_ena,
  output logic                     dut_rst_n,
  input  logic [7:0]               dut_uo_out
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] c_rst_last    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] c_settle_last = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [AW:0]   c_depth       = (AW + 1)'(DEPTH);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_rstdut = 3'd1;
  localparam logic [2:0] c_st_apply  = 3'd2;
  localparam logic [2:0] c_st_settle = 3'd3;
  localparam logic [2:0] c_st_sample = 3'd4;
  localparam logic [2:0] c_st_finish = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic [31:0]   r_mem [DEPTH];

  logic          w_load;
  logic          w_last;
  logic          w_mismatch;
  logic [15:0]   w_nxt_pins;
  logic [15:0]   w_cur_chk;

  logic          w_ld_ready_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_pass_nxt;
  logic [7:0]    w_err_nxt;
  logic [AW-1:0] w_ffi_nxt;
  logic [AW:0]   w_vc_nxt;
  logic [7:0]    w_ui_nxt;
  logic [7:0]    w_uio_nxt;
  logic          w_ena_nxt;
  logic          w_rstn_nxt;

  // ld_ready is only ever high in IDLE, so it doubles as the load qualifier.
  assign w_load     = (r_state == c_st_idle) & ld_valid & ld_ready & ~clear;
  assign w_last     = ({1'b0, r_idx} == (vec_count - (AW + 1)'(1)));
  assign w_cur_chk  = r_mem[r_idx][15:0];
  assign w_nxt_pins = r_mem[w_idx_nxt][31:16];
  assign w_mismatch = |((dut_uo_out ^ w_cur_chk[15:8]) & w_cur_chk[7:0]);

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[vec_count[AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_state_nxt = c_st_rstdut;
          w_cnt_nxt   = '0;
        end
      end
      c_st_rstdut: begin
        if (r_cnt == c_rst_last) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = (vec_count == '0) ? c_st_finish : c_st_apply;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      c_st_apply: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (SETTLE == 0) ? c_st_sample : c_st_settle;
      end
      c_st_settle: begin
        if (r_cnt == c_settle_last) begin
          w_state_nxt = c_st_sample;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      c_st_sample: begin
        if (w_last) begin
          w_state_nxt = c_st_finish;
        end else begin
          w_idx_nxt   = r_idx + AW'(1);
          w_state_nxt = c_st_apply;
        end
      end
      c_st_finish: w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy_nxt = busy;
    w_done_nxt = 1'b0;
    w_pass_nxt = pass;
    w_err_nxt  = err_count;
    w_ffi_nxt  = first_fail_idx;
    w_vc_nxt   = vec_count;
    w_ui_nxt   = dut_ui_in;
    w_uio_nxt  = dut_uio_in;
    w_ena_nxt  = dut_ena;
    w_rstn_nxt = dut_rst_n;
    case (r_state)
      c_st_idle: begin
        if (clear) begin
          w_vc_nxt   = '0;
          w_err_nxt  = '0;
          w_ffi_nxt  = '0;
          w_pass_nxt = 1'b0;
        end else if (w_load) begin
          w_vc_nxt = vec_count + (AW + 1)'(1);
        end
        if (start) begin
          w_busy_nxt = 1'b1;
          w_err_nxt  = '0;
          w_ffi_nxt  = '0;
          w_pass_nxt = 1'b0;
          w_ena_nxt  = 1'b1;
          w_rstn_nxt = 1'b0;
        end
      end
      c_st_rstdut: begin
        if (r_cnt == c_rst_last) begin
          w_rstn_nxt = 1'b1;
        end
      end
      c_st_sample: begin
        // A zero count doubles as "no mismatch seen yet" within this run.
        if (w_mismatch) begin
          if (err_count == 8'd0) begin
            w_ffi_nxt = r_idx;
          end
          if (err_count != 8'hFF) begin
            w_err_nxt = err_count + 8'd1;
          end
        end
      end
      c_st_finish: begin
        w_done_nxt = 1'b1;
        w_pass_nxt = (err_count == 8'd0);
        w_busy_nxt = 1'b0;
        w_ena_nxt  = 1'b0;
        w_rstn_nxt = 1'b0;
        w_ui_nxt   = '0;
        w_uio_nxt  = '0;
      end
      default: ;
    endcase
    // Pins change on the edge that enters APPLY, giving SETTLE+2 edges to sample.
    if (w_state_nxt == c_st_apply) begin
      w_ui_nxt  = w_nxt_pins[15:8];
      w_uio_nxt = w_nxt_pins[7:0];
    end
    w_ld_ready_nxt = (w_state_nxt == c_st_idle) && (w_vc_nxt < c_depth);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_idx          <= '0;
      ld_ready       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      vec_count      <= '0;
      dut_ui_in      <= '0;
      dut_uio_in     <= '0;
      dut_ena        <= 1'b0;
      dut_rst_n      <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_idx          <= w_idx_nxt;
      ld_ready       <= w_ld_ready_nxt;
      busy           <= w_busy_nxt;
      done           <= w_done_nxt;
      pass           <= w_pass_nxt;
      err_count      <= w_err_nxt;
      first_fail_idx <= w_ffi_nxt;
      vec_count      <= w_vc_nxt;
      dut_ui_in      <= w_ui_nxt;
      dut_uio_in     <= w_uio_nxt;
      dut_ena        <= w_ena_nxt;
      dut_rst_n      <= w_rstn_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_pin_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_tt_pin_sequencer                                           |
// | Table, directed and randomized checks of the pin sequencer.            |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_tt_pin_sequencer;

  localparam int DEPTH      = 16;
  localparam int SETTLE     = 2;
  localparam int RST_CYCLES = 4;
  localparam int AW         = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          clear;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    err_count;
  logic [AW-1:0] first_fail_idx;
  logic [AW:0]   vec_count;
  logic [7:0]    dut_ui_in;
  logic [7:0]    dut_uio_in;
  logic          dut_ena;
  logic          dut_rst_n;
  logic [7:0]    dut_uo_out;

  int checks = 0;
  int errors = 0;

  // 0: constant, 1: direct loopback of ui, 2: tile model delayed SETTLE+1 cycles
  int          uo_mode;
  logic [7:0]  uo_const;
  logic [15:0] dly [SETTLE+1];

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp_uo;
    logic [7:0] mask;
    logic [7:0] uo;
    int         err;
  } vec_t;
  vec_t tbl [6];

  tt_pin_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .clear(clear), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx), .vec_count(vec_count),
    .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in), .dut_ena(dut_ena),
    .dut_rst_n(dut_rst_n), .dut_uo_out(dut_uo_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tile_fn(input logic [7:0] ui, input logic [7:0] uio);
    return ui ^ (uio & 8'h0F);
  endfunction

  always @(posedge clk) begin
    dly[0] <= {dut_ui_in, dut_uio_in};
    for (int k = 1; k <= SETTLE; k++) dly[k] <= dly[k-1];
  end

  assign dut_uo_out = (uo_mode == 0) ? uo_const :
                      (uo_mode == 1) ? dut_ui_in :
                      tile_fn(dly[SETTLE][15:8], dly[SETTLE][7:0]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] d);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear vec_count", vec_count, 0);
  endtask

  task automatic start_run(input string nm);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, " busy after start"}, busy, 1);
    chk({nm, " ld_ready while busy"}, ld_ready, 0);
  endtask

  // cyc0: edges since the start edge already consumed by the caller.
  task automatic wait_done(input string nm, input int cyc0, input int n, input int e_err,
                           input int e_ffi, input bit e_pass, input int e_rstlow);
    int cyc;
    int rlow;
    bit hi;
    cyc  = cyc0;
    rlow = 0;
    hi   = 1'b0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (!hi) begin
        if (dut_rst_n === 1'b1) hi = 1'b1;
        else if (dut_ena === 1'b1) rlow++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, " done latency"}, cyc, RST_CYCLES + n * (SETTLE + 2) + 1);
    if (e_rstlow >= 0) chk({nm, " rst_n low cycles"}, rlow, e_rstlow);
    chk({nm, " err_count"}, err_count, e_err);
    chk({nm, " first_fail_idx"}, first_fail_idx, e_ffi);
    chk({nm, " pass"}, pass, e_pass);
    chk({nm, " busy at done"}, busy, 0);
    chk({nm, " pins parked"}, {dut_ena, dut_rst_n, dut_ui_in, dut_uio_in}, 0);
    chk({nm, " vec_count kept"}, vec_count, n);
    @(posedge clk);
    #1;
    chk({nm, " done is a pulse"}, done, 0);
    chk({nm, " ld_ready after run"}, ld_ready, (n < DEPTH) ? 1 : 0);
  endtask

  task automatic rand_run(input string nm, input int n, input bit fill_check);
    logic [7:0] ui, uio, ex, mk, act;
    int e_err;
    int e_ffi;
    e_err = 0;
    e_ffi = 0;
    do_clear();
    for (int k = 0; k < n; k++) begin
      ui  = 8'($urandom);
      uio = 8'($urandom);
      act = tile_fn(ui, uio);
      ex  = ($urandom_range(0, 1) == 1) ? act : 8'($urandom);
      mk  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (((act ^ ex) & mk) != 8'h00) begin
        if (e_err == 0) e_ffi = k;
        e_err++;
      end
      if (fill_check) chk("ld_ready before load", ld_ready, 1);
      do_load({ui, uio, ex, mk});
    end
    if (fill_check) begin
      chk("ld_ready when full", ld_ready, 0);
      chk("vec_count when full", vec_count, DEPTH);
      do_load(32'hDEADBEEF);
      chk("vec_count after overflow load", vec_count, DEPTH);
    end
    uo_mode = 2;
    start_run(nm);
    wait_done(nm, 0, n, (e_err > 255) ? 255 : e_err, e_ffi, e_err == 0, RST_CYCLES);
  endtask

  initial begin
    tbl[0] = '{ui: 8'h01, uio: 8'h00, exp_uo: 8'h01, mask: 8'hFF, uo: 8'h01, err: 0};
    tbl[1] = '{ui: 8'h02, uio: 8'h00, exp_uo: 8'hF0, mask: 8'h0F, uo: 8'h00, err: 0};
    tbl[2] = '{ui: 8'h03, uio: 8'h11, exp_uo: 8'h0F, mask: 8'h0F, uo: 8'h00, err: 1};
    tbl[3] = '{ui: 8'h04, uio: 8'h22, exp_uo: 8'h55, mask: 8'h00, uo: 8'hAA, err: 0};
    tbl[4] = '{ui: 8'h05, uio: 8'h33, exp_uo: 8'h80, mask: 8'h80, uo: 8'h7F, err: 1};
    tbl[5] = '{ui: 8'h06, uio: 8'h44, exp_uo: 8'hAA, mask: 8'hFF, uo: 8'hAA, err: 0};

    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_data  = '0;
    clear    = 1'b0;
    start    = 1'b0;
    uo_mode  = 0;
    uo_const = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ld_ready", ld_ready, 1);
    chk("reset busy/done/pass", {busy, done, pass}, 0);
    chk("reset err_count", err_count, 0);
    chk("reset first_fail_idx", first_fail_idx, 0);
    chk("reset vec_count", vec_count, 0);
    chk("reset dut pins", {dut_ui_in, dut_uio_in, dut_ena, dut_rst_n}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Three looped-back vectors.
    uo_mode = 1;
    do_load({8'h01, 8'h00, 8'h01, 8'hFF});
    do_load({8'h02, 8'h00, 8'h02, 8'hFF});
    do_load({8'h04, 8'h00, 8'h04, 8'hFF});
    chk("vec_count after 3 loads", vec_count, 3);
    start_run("loop3");
    wait_done("loop3", 0, 3, 0, 0, 1'b1, RST_CYCLES);

    // Outputs stuck at zero, then a repeat run without reload.
    uo_mode  = 0;
    uo_const = 8'h00;
    start_run("stuck0");
    wait_done("stuck0", 0, 3, 3, 0, 1'b0, RST_CYCLES);
    start_run("stuck0 rerun");
    wait_done("stuck0 rerun", 0, 3, 3, 0, 1'b0, RST_CYCLES);

    // clear, load and start are ignored while busy.
    uo_mode = 1;
    start_run("ignore");
    @(negedge clk);
    clear    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'h12345678;
    start    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    ld_valid = 1'b0;
    start    = 1'b0;
    wait_done("ignore", 1, 3, 0, 0, 1'b1, RST_CYCLES - 1);

    // Partial masks on vector 1.
    uo_mode  = 0;
    uo_const = 8'h00;
    do_clear();
    do_load({8'h01, 8'h00, 8'h00, 8'hFF});
    do_load({8'h02, 8'h00, 8'hF0, 8'h0F});
    do_load({8'h03, 8'h00, 8'h00, 8'hFF});
    start_run("mask ok");
    wait_done("mask ok", 0, 3, 0, 0, 1'b1, RST_CYCLES);
    do_clear();
    do_load({8'h01, 8'h00, 8'h00, 8'hFF});
    do_load({8'h02, 8'h00, 8'h0F, 8'h0F});
    do_load({8'h03, 8'h00, 8'h00, 8'hFF});
    start_run("mask bad");
    wait_done("mask bad", 0, 3, 1, 1, 1'b0, RST_CYCLES);

    // Single-vector table.
    for (int i = 0; i < 6; i++) begin
      do_clear();
      do_load({tbl[i].ui, tbl[i].uio, tbl[i].exp_uo, tbl[i].mask});
      uo_mode  = 0;
      uo_const = tbl[i].uo;
      start_run($sformatf("tbl%0d", i));
      wait_done($sformatf("tbl%0d", i), 0, 1, tbl[i].err, 0, tbl[i].err == 0, RST_CYCLES);
    end

    // Empty buffer run.
    do_clear();
    chk("ld_ready after clear", ld_ready, 1);
    start_run("empty");
    wait_done("empty", 0, 0, 0, 0, 1'b1, RST_CYCLES);

    // Randomized runs against the tile model, ending with a full buffer.
    for (int r = 0; r < 5; r++) begin
      rand_run($sformatf("rand%0d", r), $urandom_range(1, DEPTH - 1), 1'b0);
    end
    rand_run("full", DEPTH, 1'b1);
    do_clear();
    chk("ld_ready after full clear", ld_ready, 1);

    // Asynchronous reset during SETTLE of vector 1.
    uo_mode = 1;
    do_load({8'h01, 8'h00, 8'h01, 8'hFF});
    do_load({8'h02, 8'h00, 8'h02, 8'hFF});
    do_load({8'h04, 8'h00, 8'h04, 8'hFF});
    start_run("abort");
    repeat (9) @(posedge clk);
    #1;
    chk("abort vector1 applied", dut_ui_in, 8'h02);
    chk("abort busy before rst", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort ld_ready", ld_ready, 1);
    chk("abort vec_count", vec_count, 0);
    chk("abort dut pins", {dut_ui_in, dut_uio_in, dut_ena, dut_rst_n}, 0);
    chk("abort results", {done, pass, err_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
